// File: rtl/lane_writeback_serializer_pkg.sv
// Shared constants and state encoding for the lane writeback serializer.
package lane_writeback_serializer_pkg;

  localparam int ADDR_W_DEF = 11;
  localparam int DATA_W_DEF = 16;
  localparam int LANES_DEF  = 5;
  localparam int NUM_W      = 9;
  localparam int LANE_CNT_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_IN = 2'd1,
    ST_WRITE   = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

endpackage

// File: rtl/lane_writeback_serializer_if.sv
// Job control, vector input and memory-write bus of the serializer.
interface lane_writeback_serializer_if
  import lane_writeback_serializer_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int LANES  = LANES_DEF
);
  logic                    start;
  logic [ADDR_W-1:0]       base_addr;
  logic [NUM_W-1:0]        num_vectors;
  logic [LANES*DATA_W-1:0] in_data;
  logic                    in_valid;
  logic                    in_reverse;
  logic                    in_ready;
  logic [ADDR_W-1:0]       addr;
  logic [DATA_W-1:0]       data;
  logic                    write_enable;
  logic                    busy;
  logic                    done;

  modport master (
    output start, base_addr, num_vectors, in_data, in_valid, in_reverse,
    input  in_ready, addr, data, write_enable, busy, done
  );

  modport slave (
    input  start, base_addr, num_vectors, in_data, in_valid, in_reverse,
    output in_ready, addr, data, write_enable, busy, done
  );
endinterface

// File: rtl/lane_writeback_serializer_lane_select.sv
// Combinational lane picker: lane 0 is the most significant word of the vector.
module lane_select
  import lane_writeback_serializer_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int LANES  = LANES_DEF
) (
  input  logic [LANES*DATA_W-1:0] vec,
  input  logic [LANE_CNT_W-1:0]   lane,
  input  logic                    reverse,
  output logic [DATA_W-1:0]       word
);
  logic [DATA_W-1:0]     words [LANES];
  logic [LANE_CNT_W-1:0] idx;

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      assign words[gi] = vec[(LANES-1-gi)*DATA_W +: DATA_W];
    end
  endgenerate

  // Map the write slot to a physical lane and pick that word.
  always_comb begin
    idx  = reverse ? (LANE_CNT_W'(LANES-1) - lane) : lane;
    word = '0;
    for (int i = 0; i < LANES; i++) begin
      if (idx == LANE_CNT_W'(i)) word = words[i];
    end
  end
endmodule

// File: rtl/lane_writeback_serializer.sv
// Serializes LANES-wide vectors into consecutive single-word memory writes.
module lane_writeback_serializer
  import lane_writeback_serializer_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int LANES  = LANES_DEF
) (
  input logic clk,
  input logic rst,
  lane_writeback_serializer_if.slave bus
);
  state_t                  state_reg;
  logic [LANE_CNT_W-1:0]   lane_cnt_reg;
  logic [NUM_W-1:0]        vec_left_reg;
  logic [LANES*DATA_W-1:0] hold_reg;
  logic                    hold_rev_reg;
  logic [ADDR_W-1:0]       wr_ptr_reg;
  logic [ADDR_W-1:0]       addr_reg;
  logic [DATA_W-1:0]       data_reg;
  logic                    we_reg;
  logic                    in_ready_reg;
  logic                    busy_reg;
  logic                    done_reg;

  logic                    handshake;
  logic [LANES*DATA_W-1:0] sel_vec;
  logic                    sel_rev;
  logic [LANE_CNT_W-1:0]   sel_lane;
  logic [DATA_W-1:0]       sel_word;

  // in_ready is high exactly while in WAIT_IN, so the state alone qualifies the handshake.
  assign handshake = (state_reg == ST_WAIT_IN) && bus.in_valid;

  // Lane 0 goes out on the capture edge itself, so it is taken from the word being
  // loaded into the holding register; later lanes come from the holding register.
  assign sel_vec  = handshake ? bus.in_data    : hold_reg;
  assign sel_rev  = handshake ? bus.in_reverse : hold_rev_reg;
  assign sel_lane = handshake ? '0             : lane_cnt_reg;

  lane_select #(.DATA_W(DATA_W), .LANES(LANES)) u_lane_select (
    .vec     (sel_vec),
    .lane    (sel_lane),
    .reverse (sel_rev),
    .word    (sel_word)
  );

  assign bus.in_ready     = in_ready_reg;
  assign bus.addr         = addr_reg;
  assign bus.data         = data_reg;
  assign bus.write_enable = we_reg;
  assign bus.done         = done_reg;
  // busy already covers the cycle in which start is accepted.
  assign bus.busy         = busy_reg || ((state_reg == ST_IDLE) && bus.start && !rst);

  // Job FSM with registered outputs; addr/data only move on a write.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      lane_cnt_reg <= '0;
      vec_left_reg <= '0;
      hold_reg     <= '0;
      hold_rev_reg <= 1'b0;
      wr_ptr_reg   <= '0;
      addr_reg     <= '0;
      data_reg     <= '0;
      we_reg       <= 1'b0;
      in_ready_reg <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      we_reg   <= 1'b0;
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (bus.start) begin
            wr_ptr_reg   <= bus.base_addr;
            vec_left_reg <= bus.num_vectors;
            busy_reg     <= 1'b1;
            if (bus.num_vectors != '0) begin
              state_reg    <= ST_WAIT_IN;
              in_ready_reg <= 1'b1;
            end else begin
              state_reg <= ST_DONE;
              done_reg  <= 1'b1;
            end
          end
        end
        ST_WAIT_IN: begin
          if (handshake) begin
            hold_reg     <= bus.in_data;
            hold_rev_reg <= bus.in_reverse;
            vec_left_reg <= vec_left_reg - NUM_W'(1);
            in_ready_reg <= 1'b0;
            we_reg       <= 1'b1;
            addr_reg     <= wr_ptr_reg;
            data_reg     <= sel_word;
            wr_ptr_reg   <= wr_ptr_reg + ADDR_W'(1);
            lane_cnt_reg <= LANE_CNT_W'(1);
            state_reg    <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (lane_cnt_reg != LANE_CNT_W'(LANES)) begin
            we_reg       <= 1'b1;
            addr_reg     <= wr_ptr_reg;
            data_reg     <= sel_word;
            wr_ptr_reg   <= wr_ptr_reg + ADDR_W'(1);
            lane_cnt_reg <= lane_cnt_reg + LANE_CNT_W'(1);
          end else begin
            lane_cnt_reg <= '0;
            if (vec_left_reg != '0) begin
              state_reg    <= ST_WAIT_IN;
              in_ready_reg <= 1'b1;
            end else begin
              state_reg <= ST_DONE;
              done_reg  <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          busy_reg  <= 1'b0;
          state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end
endmodule
